// File: rtl/dvi_timing_pkg.sv
// Shared types and helpers for the DVI raster sequencer.
// Latency: none; backpressure: none.
package dvi_timing_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef logic [11:0] coord_t;

  function automatic coord_t calc_total(input int active, input int fp, input int sync, input int bp);
    return coord_t'(active + fp + sync + bp);
  endfunction

endpackage

// File: rtl/dvi_pipe_delay.sv
// Fixed-depth shift register with synchronous clear, aligns raster control with fetched pixels.
// Latency: DEPTH cycles; backpressure: none, shifts every cycle.
module dvi_pipe_delay #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/dvi_timing_ctrl.sv
// Raster timing generator: issues framebuffer fetches and realigns returned RGB with DE/sync for the TMDS encoders.
// Latency: request 1 cycle after counter, encoder outputs PIPE+1 cycles after request; backpressure: none, free-running raster.
module dvi_timing_ctrl
  import dvi_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIPE      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        req_valid,
  output logic [11:0] req_x,
  output logic [11:0] req_y,
  input  logic [23:0] pix_rgb,
  output logic        enc_de,
  output logic [1:0]  enc_ctrl_b,
  output logic [1:0]  enc_ctrl_g,
  output logic [1:0]  enc_ctrl_r,
  output logic [7:0]  enc_r,
  output logic [7:0]  enc_g,
  output logic [7:0]  enc_b,
  output logic        frame_start,
  output logic        busy
);

  localparam coord_t H_TOT  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam coord_t V_TOT  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  state_t     state, state_nxt;
  coord_t     hc, vc, hc_nxt, vc_nxt;
  logic       stop_q, stop_nxt;
  logic [3:0] dcnt, dcnt_nxt;
  logic       run, wrap;
  logic       active, hs, vs;
  logic       req_hs, req_vs, req_fs;
  logic       d_act, d_hs, d_vs, d_fs;

  assign wrap   = (hc == H_TOT - 12'd1) && (vc == V_TOT - 12'd1);
  assign active = (hc < H_ACT) && (vc < V_ACT);
  assign hs     = (hc >= HS_BEG) && (hc < HS_END);
  assign vs     = (vc >= VS_BEG) && (vc < VS_END);

  // IDLE with enable already counts as a running cycle so (0,0) is requested immediately.
  always_comb begin
    state_nxt = state;
    stop_nxt  = stop_q;
    dcnt_nxt  = dcnt;
    hc_nxt    = hc;
    vc_nxt    = vc;
    run       = 1'b0;
    case (state)
      IDLE: begin
        stop_nxt = 1'b0;
        if (enable) begin
          state_nxt = RUN;
          run       = 1'b1;
        end
      end
      RUN: begin
        run      = 1'b1;
        stop_nxt = !enable;
        dcnt_nxt = '0;
        if (wrap && stop_q) begin
          state_nxt = DRAIN;
          stop_nxt  = 1'b0;
        end
      end
      DRAIN: begin
        if (dcnt == 4'(PIPE)) state_nxt = IDLE;
        else                  dcnt_nxt  = dcnt + 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
    if (run) begin
      if (hc == H_TOT - 12'd1) begin
        hc_nxt = '0;
        vc_nxt = (vc == V_TOT - 12'd1) ? '0 : vc + 12'd1;
      end else begin
        hc_nxt = hc + 12'd1;
      end
    end else begin
      hc_nxt = '0;
      vc_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      stop_q <= 1'b0;
      dcnt   <= '0;
      hc     <= '0;
      vc     <= '0;
    end else begin
      state  <= state_nxt;
      stop_q <= stop_nxt;
      dcnt   <= dcnt_nxt;
      hc     <= hc_nxt;
      vc     <= vc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid <= 1'b0;
      req_x     <= '0;
      req_y     <= '0;
      req_hs    <= 1'b0;
      req_vs    <= 1'b0;
      req_fs    <= 1'b0;
    end else begin
      req_valid <= run && active;
      req_x     <= (run && active) ? hc : '0;
      req_y     <= (run && active) ? vc : '0;
      req_hs    <= run && hs;
      req_vs    <= run && vs;
      req_fs    <= run && active && (hc == '0) && (vc == '0);
    end
  end

  dvi_pipe_delay #(.WIDTH(4), .DEPTH(PIPE)) u_ctrl_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({req_valid, req_hs, req_vs, req_fs}),
    .dout ({d_act, d_hs, d_vs, d_fs})
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_de      <= 1'b0;
      enc_ctrl_b  <= {~VSYNC_POL, ~HSYNC_POL};
      enc_r       <= '0;
      enc_g       <= '0;
      enc_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      enc_de      <= d_act;
      enc_ctrl_b  <= {d_vs ^ ~VSYNC_POL, d_hs ^ ~HSYNC_POL};
      enc_r       <= d_act ? pix_rgb[23:16] : 8'h00;
      enc_g       <= d_act ? pix_rgb[15:8]  : 8'h00;
      enc_b       <= d_act ? pix_rgb[7:0]   : 8'h00;
      frame_start <= d_fs;
    end
  end

  assign enc_ctrl_g = 2'b00;
  assign enc_ctrl_r = 2'b00;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Scoreboard bench for dvi_timing_ctrl: small raster for alignment/stop/reset, default raster for line geometry.
module tb_dvi_timing_ctrl;

  localparam int PIPE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable;
  logic        req_valid;
  logic [11:0] req_x, req_y;
  logic [23:0] pix_rgb;
  logic        enc_de;
  logic [1:0]  enc_ctrl_b, enc_ctrl_g, enc_ctrl_r;
  logic [7:0]  enc_r, enc_g, enc_b;
  logic        frame_start, busy;

  dvi_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE(PIPE)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .pix_rgb(pix_rgb),
    .enc_de(enc_de), .enc_ctrl_b(enc_ctrl_b), .enc_ctrl_g(enc_ctrl_g), .enc_ctrl_r(enc_ctrl_r),
    .enc_r(enc_r), .enc_g(enc_g), .enc_b(enc_b), .frame_start(frame_start), .busy(busy)
  );

  logic        enable2;
  logic        req_valid2;
  logic [11:0] req_x2, req_y2;
  logic [23:0] pix_rgb2;
  logic        enc_de2;
  logic [1:0]  enc_ctrl_b2, enc_ctrl_g2, enc_ctrl_r2;
  logic [7:0]  enc_r2, enc_g2, enc_b2;
  logic        frame_start2, busy2;

  assign pix_rgb2 = 24'h000000;

  dvi_timing_ctrl dut_vga (
    .clk(clk), .rst(rst), .enable(enable2),
    .req_valid(req_valid2), .req_x(req_x2), .req_y(req_y2), .pix_rgb(pix_rgb2),
    .enc_de(enc_de2), .enc_ctrl_b(enc_ctrl_b2), .enc_ctrl_g(enc_ctrl_g2), .enc_ctrl_r(enc_ctrl_r2),
    .enc_r(enc_r2), .enc_g(enc_g2), .enc_b(enc_b2), .frame_start(frame_start2), .busy(busy2)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int npix = 0;
  logic [24:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer model: returns {row, col, A5} PIPE cycles after a request, junk otherwise.
  logic [23:0] fb [PIPE];
  always @(posedge clk) begin
    fb[0] <= req_valid ? {req_y[7:0], req_x[7:0], 8'hA5} : 24'h5A5A5A;
    for (int i = 1; i < PIPE; i++) fb[i] <= fb[i-1];
  end
  assign pix_rgb = fb[PIPE-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        exp_q.push_back({(x == 0 && y == 0), y[7:0], x[7:0], 8'hA5});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Monitor: pops expected pixels on every enc_de cycle and checks raster timing from frame_start.
  initial begin
    logic [24:0] e;
    int k, h, v;
    logic ph_ok;
    k = 0;
    ph_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph_ok = 1'b0;
      end else begin
        if (frame_start) begin
          if (ph_ok) check("frame_period", k, 48);
          ph_ok = 1'b1;
          k = 0;
        end
        if (ph_ok && k < 48) begin
          h = k % 8;
          v = k / 8;
          check("timing_de_vs_hs", {enc_de, enc_ctrl_b}, {(h < 4 && v < 3), !(v == 4), !(h >= 5 && h < 7)});
        end
        if (enc_de) begin
          check("de_has_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            npix++;
            check("pixel_fs_rgb", {frame_start, enc_r, enc_g, enc_b}, e);
          end
        end else begin
          check("blank_zero", {frame_start, enc_r, enc_g, enc_b}, 25'h0);
        end
        if (!busy) ph_ok = 1'b0;
        k++;
      end
    end
  end

  initial begin
    int s;
    int t_r1, t_f, t_r2, t_hf, t_hr, maxx, nfs;
    logic pde, phs;
    rst = 1'b1;
    enable = 1'b0;
    enable2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {req_valid, req_x, req_y, enc_de, enc_ctrl_b, enc_ctrl_g, enc_ctrl_r, enc_r, enc_g, enc_b, frame_start, busy},
          {1'b0, 12'd0, 12'd0, 1'b0, 2'b11, 2'b00, 2'b00, 24'd0, 1'b0, 1'b0});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Three frames, enable dropped mid third frame.
    push_frame(); push_frame(); push_frame();
    enable = 1'b1;
    s = cyc + 1;
    repeat (116) @(negedge clk);
    enable = 1'b0;
    wait_idle();
    check("drain_busy_fall_cycle", cyc, s + 143 + PIPE + 1);
    check("frames_completed", npix, 36);
    check("idle_outputs", {req_valid, enc_de, enc_ctrl_b, enc_r, enc_g, enc_b},
          {1'b0, 1'b0, 2'b11, 24'd0});

    // Restart from IDLE.
    repeat (3) @(negedge clk);
    push_frame();
    enable = 1'b1;
    @(negedge clk);
    check("restart_req", {busy, req_valid, req_x, req_y, enc_de}, {1'b1, 1'b1, 12'd0, 12'd0, 1'b0});
    repeat (PIPE) @(negedge clk);
    check("restart_pre_de", enc_de, 1'b0);
    @(negedge clk);
    check("restart_first_de", {enc_de, frame_start}, 2'b11);
    enable = 1'b0;
    wait_idle();
    check("restart_frame_done", {npix, exp_q.size()}, {32'd48, 32'd0});

    // Reset while hc=2 of the first line.
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_req_x", {req_valid, req_x}, {1'b1, 12'd1});
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("midline_reset_outputs",
          {req_valid, req_x, req_y, enc_de, enc_ctrl_b, enc_ctrl_g, enc_ctrl_r, enc_r, enc_g, enc_b, frame_start, busy},
          {1'b0, 12'd0, 12'd0, 1'b0, 2'b11, 2'b00, 2'b00, 24'd0, 1'b0, 1'b0});
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_reset_quiet", {busy, enc_de, npix}, {1'b0, 1'b0, 32'd48});
    push_frame();
    enable = 1'b1;
    @(negedge clk);
    check("reenable_req", {req_valid, req_x, req_y}, {1'b1, 12'd0, 12'd0});
    repeat (4) @(negedge clk);
    enable = 1'b0;
    wait_idle();
    check("clean_frame_done", {npix, exp_q.size()}, {32'd60, 32'd0});

    // Default 640x480 raster: line geometry over two lines.
    t_r1 = -1; t_f = -1; t_r2 = -1; t_hf = -1; t_hr = -1; maxx = 0; nfs = 0;
    pde = 1'b0; phs = 1'b1;
    enable2 = 1'b1;
    for (int i = 0; i < 1800; i++) begin
      @(negedge clk);
      if (enc_de2 && !pde) begin
        if (t_r1 < 0) t_r1 = i;
        else if (t_r2 < 0) t_r2 = i;
      end
      if (!enc_de2 && pde && t_f < 0 && t_r1 >= 0) t_f = i;
      if (!enc_ctrl_b2[0] && phs && t_hf < 0 && t_r1 >= 0) t_hf = i;
      if (enc_ctrl_b2[0] && !phs && t_hr < 0 && t_hf >= 0) t_hr = i;
      if (req_valid2 && int'(req_x2) > maxx) maxx = int'(req_x2);
      if (frame_start2) nfs++;
      pde = enc_de2;
      phs = enc_ctrl_b2[0];
    end
    check("vga_line_period", t_r2 - t_r1, 800);
    check("vga_de_width", t_f - t_r1, 640);
    check("vga_hs_offset", t_hf - t_r1, 656);
    check("vga_hs_width", t_hr - t_hf, 96);
    check("vga_max_x", maxx, 639);
    check("vga_misc", {busy2, nfs, enc_ctrl_b2[1], enc_ctrl_g2, enc_ctrl_r2, enc_r2, enc_g2, enc_b2, req_y2 <= 12'd2},
          {1'b1, 32'd1, 1'b1, 2'b00, 2'b00, 24'd0, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
